// File: rtl/digit_reg_bank_if.sv
// Request/status bundle for digit_reg_bank: the controller drives requests and
// observes the registered digit contents, change flags and error flag.
interface digit_reg_bank_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 8
);
    localparam int ADDR_W = $clog2(NUM_DIGITS);

    logic                          wr_en;
    logic [ADDR_W-1:0]             wr_addr;
    logic [DIGIT_W-1:0]            wr_data;
    logic                          shift_en;
    logic                          clr;
    logic                          flag_ack;
    logic [NUM_DIGITS*DIGIT_W-1:0] digits_out;
    logic [NUM_DIGITS-1:0]         changed;
    logic                          flag_out;
    logic                          err_out;

    modport master (
        output wr_en, wr_addr, wr_data, shift_en, clr, flag_ack,
        input  digits_out, changed, flag_out, err_out
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, shift_en, clr, flag_ack,
        output digits_out, changed, flag_out, err_out
    );
endinterface

// File: rtl/digit_reg_bank.sv
// Bank of display digit registers with addressed write, scroll-in shift and clear,
// plus sticky per-digit change flags and a sticky out-of-range address error.
module digit_reg_bank #(
    parameter int                 NUM_DIGITS = 4,
    parameter int                 DIGIT_W    = 8,
    parameter logic [DIGIT_W-1:0] RESET_VAL  = {DIGIT_W{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    digit_reg_bank_if.slave  bus
);
    localparam int ADDR_W = $clog2(NUM_DIGITS);

    logic [DIGIT_W-1:0]    digit_q   [NUM_DIGITS];
    logic [DIGIT_W-1:0]    digit_nxt [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] changed_q;
    logic [NUM_DIGITS-1:0] changed_nxt;
    logic                  flag_q;
    logic                  err_q;
    logic                  err_nxt;
    logic                  addr_ok;

    assign addr_ok = int'(bus.wr_addr) < NUM_DIGITS;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        digit_nxt   = digit_q;
        err_nxt     = err_q;
        changed_nxt = '0;

        // clr outranks shift_en, which outranks wr_en; losers are dropped.
        if (bus.clr) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit_nxt[i] = RESET_VAL;
        end else if (bus.shift_en) begin
            digit_nxt[0] = bus.wr_data;
            for (int i = 1; i < NUM_DIGITS; i++) digit_nxt[i] = digit_q[i-1];
        end else if (bus.wr_en) begin
            if (addr_ok) digit_nxt[bus.wr_addr] = bus.wr_data;
            else         err_nxt = 1'b1;
        end

        // A real change in the same cycle as an ack keeps the flag set.
        for (int i = 0; i < NUM_DIGITS; i++)
            changed_nxt[i] = (changed_q[i] & ~bus.flag_ack) | (digit_nxt[i] != digit_q[i]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the digit array is reset because its reset contents are visible on digits_out.
            for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= RESET_VAL;
            changed_q <= '1;
            flag_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            digit_q   <= digit_nxt;
            changed_q <= changed_nxt;
            flag_q    <= |changed_nxt;
            err_q     <= err_nxt;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_pack
        assign bus.digits_out[g*DIGIT_W +: DIGIT_W] = digit_q[g];
    end

    assign bus.changed  = changed_q;
    assign bus.flag_out = flag_q;
    assign bus.err_out  = err_q;
endmodule

// File: doc/digit_reg_bank.md
DIGIT_REG_BANK -- requirements
Module: digit_reg_bank

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of digit registers, legal range 2..16.
REQ-002 Parameter DIGIT_W, default 8: width of each digit register in bits.
REQ-003 Parameter RESET_VAL, default 8'hFF (all ones at DIGIT_W): value loaded into every digit on reset and on clear.
REQ-004 Parameter ADDR_W: derived as clog2(NUM_DIGITS), not overridden.
REQ-005 Clock clk; reset reset, asynchronous, active-high.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 wr_en  input  1  addressed write request.
REQ-009 wr_addr  input  ADDR_W  digit index for wr_en.
REQ-010 wr_data  input  DIGIT_W  data for addressed write or shift-in.
REQ-011 shift_en  input  1  scroll request: digits move up one index, wr_data enters at index 0.
REQ-012 clr  input  1  synchronous clear of all digits to RESET_VAL.
REQ-013 flag_ack  input  1  clears all change flags.
REQ-014 digits_out  output  NUM_DIGITS*DIGIT_W  registered digit contents; digit i at bits [i*DIGIT_W +: DIGIT_W].
REQ-015 changed  output  NUM_DIGITS  registered sticky per-digit change flags.
REQ-016 flag_out  output  1  registered OR of all change flags.
REQ-017 err_out  output  1  registered sticky flag for an out-of-range address.

Function
REQ-018 The block SHALL apply one operation per cycle, with priority clr > shift_en > wr_en; lower-priority requests in the same cycle SHALL be dropped.
REQ-019 An accepted wr_en with wr_addr < NUM_DIGITS SHALL update only that digit, with wr_data visible on digits_out one cycle after the sampling edge.
REQ-020 A wr_en with wr_addr >= NUM_DIGITS SHALL leave every digit unchanged and set err_out, which stays set until reset.
REQ-021 On shift_en, digit[i] SHALL take the value of digit[i-1] for i = 1..NUM_DIGITS-1, digit[0] SHALL take wr_data, and the old digit[NUM_DIGITS-1] SHALL be discarded.
REQ-022 On clr, every digit SHALL take RESET_VAL in the next cycle; err_out SHALL be unaffected.
REQ-023 changed[i] SHALL set in the same cycle digit i is updated, but only if the new value differs from the old; a write of an identical value SHALL NOT set it.
REQ-024 changed[i] SHALL remain set until a cycle with flag_ack = 1.
REQ-025 If flag_ack and a new change to digit i occur in the same cycle, changed[i] SHALL be 1 afterwards (the change wins over the ack).
REQ-026 flag_out SHALL equal the OR of the next-state changed vector, so it is cycle-aligned with changed; no extra latency.
REQ-027 With no request active, all outputs SHALL hold their values.
REQ-028 Inputs SHALL be treated as synchronous to clk; no handshake or backpressure exists, and every request is accepted or dropped in its cycle.

Reset
REQ-029 While reset = 1, every digit SHALL be RESET_VAL, changed all ones, flag_out = 1 and err_out = 0, asynchronously and regardless of clk.
REQ-030 Reset asserted mid-operation SHALL abort any pending update; the first rising clk edge after reset deasserts SHALL process inputs normally.

Verification (NUM_DIGITS=4, DIGIT_W=8, RESET_VAL=8'hFF)
REQ-031 Pulse reset, then pulse flag_ack -> digits_out = 32'hFFFFFFFF, changed 4'b1111 and flag_out 1 until the ack, then changed 4'b0000 and flag_out 0.
REQ-032 After ack, wr_en with addr 2 and data 8'h35; one cycle later repeat the same write -> digits_out = 32'hFF35FFFF, changed = 4'b0100 after the first write and unchanged by the second.
REQ-033 Four consecutive shift_en cycles with data 8'h31, 8'h32, 8'h33, 8'h34 -> digits_out = 32'h31323334 and changed = 4'b1111.
REQ-034 clr, shift_en and wr_en (addr 0, data 8'h41) in the same cycle -> all digits 8'hFF, no shift and no write.
REQ-035 flag_ack in the same cycle as a write of 8'h39 to digit 1 (old value 8'hFF) -> changed = 4'b0010 and flag_out = 1.
REQ-036 With NUM_DIGITS=3, wr_en with addr 3 -> digits unchanged and err_out = 1; clr leaves err_out = 1; reset clears it to 0.
